bar_stream_rx: RTL

//  Receiving end of the bar data/valid/ready stream: accepts words from a producer that

---
 rtl/bar_stream_pkg.sv | 16 +
 rtl/bar_stream_rx_mem.sv | 23 ++
 rtl/bar_stream_rx.sv | 109 ++++++++++
 3 files changed

// File: rtl/bar_stream_pkg.sv
// Shared types and helpers for the bar data/valid/ready stream.
package bar_stream_pkg;

  localparam int unsigned BAR_WIDTH = 32;

  typedef logic [31:0] bar_word_t;

  // Occupancy next-state for a FIFO with independent push and pop strobes.
  function automatic int unsigned occ_next(input int unsigned occ, input logic push,
                                           input logic pop);
    if (push && !pop) return occ + 1;
    if (pop && !push) return occ - 1;
    return occ;
  endfunction

endpackage

// File: rtl/bar_stream_rx_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module bar_stream_rx_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bar_stream_rx.sv
// Receiving end of a bar stream: FWFT FIFO plus accepted-word counter.
// Optional running XOR checksum port enabled by BAR_STREAM_RX_CKSUM_EN.
module bar_stream_rx import bar_stream_pkg::*; #(
  parameter int unsigned WIDTH = BAR_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output bar_word_t                  accepted_cnt
`ifdef BAR_STREAM_RX_CKSUM_EN
  ,
  output logic [WIDTH-1:0]           cksum
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LvlFull = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  bar_word_t        cnt_q, cnt_d;
  logic [WIDTH-1:0] rd_data;
  logic             push, pop, we;

  // Handshake qualifiers depend only on registered occupancy: no full or empty bypass.
  assign in_ready  = (level_q != LvlFull);
  assign out_valid = (level_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign we        = push & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        cnt_d    = cnt_q + 32'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = (AW + 1)'(occ_next(32'(level_q), push, pop));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
    end
  end

  bar_stream_rx_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // Storage is not reset, so mask the head word while empty.
  assign out_data     = out_valid ? rd_data : '0;
  assign level        = level_q;
  assign accepted_cnt = cnt_q;

`ifdef BAR_STREAM_RX_CKSUM_EN
  logic [WIDTH-1:0] cksum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cksum_q <= '0;
    end else if (flush) begin
      cksum_q <= '0;
    end else if (push) begin
      cksum_q <= cksum_q ^ in_data;
    end
  end

  assign cksum = cksum_q;
`endif

endmodule
